// File: rtl/fc_sched_if.sv
// fc_sched_if: bus bundle between the FC sequencer and its host / memories.
//
// Signals:
//   start     host -> seq    begin one full layer evaluation (sampled in IDLE only)
//   busy      seq  -> host   high whenever the sequencer is not idle
//   done      seq  -> host   one-cycle pulse after the last result is written
//   in_addr   seq  -> mem    input-vector buffer read address
//   in_data   mem  -> seq    input-vector read data, 1 cycle after in_addr
//   w_addr    seq  -> mem    weight memory read address (pass*NUM_IN + idx)
//   w_data    mem  -> seq    LANES packed weights, slice l feeds lane l
//   res_we    seq  -> rbuf   result write strobe
//   res_addr  seq  -> rbuf   result (neuron) index
//   res_data  seq  -> rbuf   requantised result word
//
// Modports: master = host/memory side, slave = the sequencer.
interface fc_sched_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 100,
  parameter int unsigned NUM_OUT    = 10,
  parameter int unsigned LANES      = 5
);
  localparam int unsigned Passes   = (NUM_OUT + LANES - 1) / LANES;
  localparam int unsigned InAddrW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned WAddrW   = (Passes * NUM_IN > 1) ? $clog2(Passes * NUM_IN) : 1;
  localparam int unsigned ResAddrW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                        start;
  logic                        busy;
  logic                        done;
  logic [InAddrW-1:0]          in_addr;
  logic [DATA_WIDTH-1:0]       in_data;
  logic [WAddrW-1:0]           w_addr;
  logic [LANES*DATA_WIDTH-1:0] w_data;
  logic                        res_we;
  logic [ResAddrW-1:0]         res_addr;
  logic [DATA_WIDTH-1:0]       res_data;

  modport master (
    output start, in_data, w_data,
    input  busy, done, in_addr, w_addr, res_we, res_addr, res_data
  );

  modport slave (
    input  start, in_data, w_data,
    output busy, done, in_addr, w_addr, res_we, res_addr, res_data
  );
endinterface

// File: rtl/fc_sched.sv
// fc_sched: time-multiplexed fully-connected layer sequencer.
//
// A bank of LANES MAC lanes is reused over ceil(NUM_OUT/LANES) passes. Each pass streams the
// whole input vector (FETCH), absorbs the last in-flight product (TAIL), then writes one
// requantised result per cycle for every valid lane of the pass (WRITE). DONE pulses once.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   fc_sched_if.slave: start/busy/done handshake, input/weight read ports (1-cycle
//         read latency) and the result write port.
//
// Build option: define FC_SCHED_RELU_EN to clamp negative results to zero at writeback.
// Timing is the same either way.
module fc_sched #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 100,
  parameter int unsigned NUM_OUT    = 10,
  parameter int unsigned LANES      = 5,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input logic       clk,
  input logic       rst,
  fc_sched_if.slave bus
);

  localparam int unsigned Passes   = (NUM_OUT + LANES - 1) / LANES;
  localparam int unsigned InAddrW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned WAddrW   = (Passes * NUM_IN > 1) ? $clog2(Passes * NUM_IN) : 1;
  localparam int unsigned ResAddrW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned PassW    = (Passes > 1) ? $clog2(Passes) : 1;
  localparam int unsigned LaneW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ProdW    = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StTail,
    StWrite,
    StDone
  } state_e;

  state_e                      state_q, state_d;
  logic [PassW-1:0]            pass_q, pass_d;
  logic [InAddrW-1:0]          idx_q, idx_d;
  logic [LaneW-1:0]            lane_q, lane_d;
  // Marks that in_data/w_data this cycle answer an address issued last cycle.
  logic                        vld_q, vld_d;
  logic signed [ACC_WIDTH-1:0] acc_q [LANES];
  logic signed [ACC_WIDTH-1:0] acc_d [LANES];

  logic signed [ProdW-1:0]     prod [LANES];
  logic [LaneW-1:0]            last_lane;
  logic                        last_pass;
  logic                        last_idx;
  int unsigned                 remain;

  logic signed [ACC_WIDTH-1:0] sel_acc;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [ACC_WIDTH-DATA_WIDTH:0] upper;
  logic [DATA_WIDTH-1:0]       requant;

  // Full-width signed products; both operands are signed so they sign-extend to ProdW.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = $signed(bus.in_data) * $signed(bus.w_data[l*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // The final pass may hold fewer live neurons than there are lanes.
  always_comb begin
    remain = NUM_OUT - 32'(pass_q) * LANES;
    if (remain >= LANES) begin
      last_lane = LaneW'(LANES - 1);
    end else begin
      last_lane = LaneW'(remain - 1);
    end
  end

  assign last_pass = (pass_q == PassW'(Passes - 1));
  assign last_idx  = (idx_q == InAddrW'(NUM_IN - 1));

  // Requantise: arithmetic shift (floor), saturate to DATA_WIDTH, optional ReLU.
  always_comb begin
    sel_acc = acc_q[lane_q];
    shifted = sel_acc >>> FRAC_BITS;
    upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    if ((&upper) || !(|upper)) begin
      requant = shifted[DATA_WIDTH-1:0];
    end else if (shifted[ACC_WIDTH-1]) begin
      requant = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      requant = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`ifdef FC_SCHED_RELU_EN
    if (requant[DATA_WIDTH-1]) begin
      requant = '0;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    vld_d   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      acc_d[l] = acc_q[l];
      if (vld_q) begin
        acc_d[l] = acc_q[l] + ACC_WIDTH'(prod[l]);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFetch;
          pass_d  = '0;
          idx_d   = '0;
          lane_d  = '0;
          for (int l = 0; l < LANES; l++) begin
            acc_d[l] = '0;
          end
        end
      end
      StFetch: begin
        vld_d = 1'b1;
        if (last_idx) begin
          idx_d   = '0;
          state_d = StTail;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StTail: begin
        state_d = StWrite;
        lane_d  = '0;
      end
      StWrite: begin
        if (lane_q == last_lane) begin
          lane_d = '0;
          if (last_pass) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
            pass_d  = pass_q + 1'b1;
            idx_d   = '0;
            for (int l = 0; l < LANES; l++) begin
              acc_d[l] = '0;
            end
          end
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are pure functions of state so reset clears them on the following cycle.
  always_comb begin
    bus.busy     = (state_q != StIdle);
    bus.done     = (state_q == StDone);
    bus.in_addr  = '0;
    bus.w_addr   = '0;
    bus.res_we   = 1'b0;
    bus.res_addr = '0;
    bus.res_data = '0;
    if (state_q == StFetch) begin
      bus.in_addr = idx_q;
      bus.w_addr  = WAddrW'(32'(pass_q) * NUM_IN + 32'(idx_q));
    end
    if (state_q == StWrite) begin
      bus.res_we   = 1'b1;
      bus.res_addr = ResAddrW'(32'(pass_q) * LANES + 32'(lane_q));
      bus.res_data = requant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pass_q  <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      vld_q   <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      vld_q   <= vld_d;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
      end
    end
  end

endmodule

// File: tb/tb_fc_sched.sv
// Self-checking bench for fc_sched with NUM_IN=4, NUM_OUT=3, LANES=2.
// The reference model computes each neuron's dot product with longint arithmetic and builds
// the expected cycle-by-cycle schedule from the pass/lane timing rules.
module tb_fc_sched;
  localparam int unsigned DW = 16;
  localparam int unsigned NI = 4;
  localparam int unsigned NO = 3;
  localparam int unsigned LN = 2;
  localparam int unsigned FB = 8;
  localparam int unsigned AW = 40;
  localparam int unsigned NP = (NO + LN - 1) / LN;
  localparam int MaxK = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fc_sched_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .LANES(LN)) bus ();

  fc_sched #(
    .DATA_WIDTH(DW),
    .NUM_IN    (NI),
    .NUM_OUT   (NO),
    .LANES     (LN),
    .FRAC_BITS (FB),
    .ACC_WIDTH (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0]    in_mem [NI];
  logic [LN*DW-1:0] w_mem  [NP*NI];

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    bus.w_data  <= w_mem[bus.w_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  bit            exp_we    [MaxK];
  int            exp_addr  [MaxK];
  logic [DW-1:0] exp_data  [MaxK];
  bit            exp_fetch [MaxK];
  int            exp_in    [MaxK];
  int            exp_w     [MaxK];

  function automatic logic [DW-1:0] model_res(input int n);
    longint           acc;
    logic [LN*DW-1:0] row;
    logic [DW-1:0]    wv;
    int               p;
    int               l;
    p   = n / LN;
    l   = n % LN;
    acc = 0;
    for (int i = 0; i < NI; i++) begin
      row = w_mem[p*NI + i];
      wv  = row[l*DW +: DW];
      acc += longint'($signed(in_mem[i])) * longint'($signed(wv));
    end
    acc = acc >>> FB;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef FC_SCHED_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return DW'(acc);
  endfunction

  // Cycle k is k cycles after the start-sampling cycle S.
  task automatic build_sched(output int done_k);
    int t;
    int nl;
    for (int k = 0; k < MaxK; k++) begin
      exp_we[k] = 0; exp_addr[k] = 0; exp_data[k] = '0;
      exp_fetch[k] = 0; exp_in[k] = 0; exp_w[k] = 0;
    end
    t = 1;
    for (int p = 0; p < int'(NP); p++) begin
      for (int i = 0; i < int'(NI); i++) begin
        exp_fetch[t] = 1; exp_in[t] = i; exp_w[t] = p*NI + i;
        t++;
      end
      t++;
      nl = (int'(NO) - p*int'(LN) < int'(LN)) ? int'(NO) - p*int'(LN) : int'(LN);
      for (int l = 0; l < nl; l++) begin
        exp_we[t] = 1; exp_addr[t] = p*LN + l; exp_data[t] = model_res(p*LN + l);
        t++;
      end
    end
    done_k = t;
  endtask

  // Caller is at a negedge in IDLE; start is raised here so this cycle is S.
  task automatic run_layer(input bit busy_pulses, input int rst_at);
    int   done_k;
    logic eb;
    build_sched(done_k);
    bus.start = 1'b1;
    for (int k = 1; k <= done_k + 1; k++) begin
      @(negedge clk);
      if (rst_at > 0 && k == rst_at + 1) begin
        n_checks++;
        if (bus.busy !== 1'b0 || bus.res_we !== 1'b0 || bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_ctrl k=%0d: busy=%b we=%b done=%b, required 0/0/0",
                   k, bus.busy, bus.res_we, bus.done);
        end
        n_checks++;
        if (bus.in_addr !== '0 || bus.w_addr !== '0 || bus.res_addr !== '0 ||
            bus.res_data !== '0) begin
          n_fail++;
          $display("FAIL rst_outs k=%0d: in_addr=%h w_addr=%h res_addr=%h res_data=%h, required 0",
                   k, bus.in_addr, bus.w_addr, bus.res_addr, bus.res_data);
        end
        rst = 1'b1;
        return;
      end
      eb = (k <= done_k);
      n_checks++;
      if (bus.busy !== eb) begin
        n_fail++;
        $display("FAIL busy k=%0d: got %b required %b", k, bus.busy, eb);
      end
      eb = (k == done_k);
      n_checks++;
      if (bus.done !== eb) begin
        n_fail++;
        $display("FAIL done k=%0d: got %b required %b", k, bus.done, eb);
      end
      eb = exp_we[k];
      n_checks++;
      if (bus.res_we !== eb) begin
        n_fail++;
        $display("FAIL res_we k=%0d: got %b required %b", k, bus.res_we, eb);
      end
      if (exp_we[k]) begin
        n_checks++;
        if (32'(bus.res_addr) !== 32'(exp_addr[k])) begin
          n_fail++;
          $display("FAIL res_addr k=%0d: got %0d required %0d", k, bus.res_addr, exp_addr[k]);
        end
        n_checks++;
        if (bus.res_data !== exp_data[k]) begin
          n_fail++;
          $display("FAIL res_data k=%0d: got %h required %h", k, bus.res_data, exp_data[k]);
        end
      end
      if (exp_fetch[k]) begin
        n_checks++;
        if (32'(bus.in_addr) !== 32'(exp_in[k])) begin
          n_fail++;
          $display("FAIL in_addr k=%0d: got %0d required %0d", k, bus.in_addr, exp_in[k]);
        end
        n_checks++;
        if (32'(bus.w_addr) !== 32'(exp_w[k])) begin
          n_fail++;
          $display("FAIL w_addr k=%0d: got %0d required %0d", k, bus.w_addr, exp_w[k]);
        end
      end
      bus.start = busy_pulses && (k == 3 || k == 10);
      if (k == rst_at) rst = 1'b0;
    end
  endtask

  task automatic fill(input logic [DW-1:0] iv, input logic [DW-1:0] wv);
    for (int i = 0; i < int'(NI); i++) in_mem[i] = iv;
    for (int j = 0; j < int'(NP*NI); j++) w_mem[j] = {LN{wv}};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.res_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b we=%b, required 0/0/0",
               bus.busy, bus.done, bus.res_we);
    end
    n_checks++;
    if (bus.in_addr !== '0 || bus.w_addr !== '0 || bus.res_addr !== '0 ||
        bus.res_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: in_addr=%h w_addr=%h res_addr=%h res_data=%h, required 0",
               bus.in_addr, bus.w_addr, bus.res_addr, bus.res_data);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill(16'h0100, 16'h0080);
    run_layer(1'b0, 0);
  endtask

  task automatic test_saturation();
    fill(16'h7FFF, 16'h7FFF);
    run_layer(1'b0, 0);
    fill(16'h8000, 16'h7FFF);
    run_layer(1'b0, 0);
  endtask

  task automatic test_start_while_busy();
    fill(16'h0100, 16'h0080);
    run_layer(1'b1, 0);
    // A queued second run would show busy here.
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_rerun: busy=%b required 0", bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill(16'h0100, 16'h0080);
    run_layer(1'b0, 6);
    @(negedge clk);
    run_layer(1'b0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'(NI); i++) begin
        in_mem[i] = (r % 2 == 1) ? DW'($urandom_range(0, 2047) - 1024) : DW'($urandom);
      end
      for (int j = 0; j < int'(NP*NI); j++) begin
        for (int l = 0; l < int'(LN); l++) begin
          w_mem[j][l*DW +: DW] = (r % 2 == 1) ? DW'($urandom_range(0, 2047) - 1024)
                                              : DW'($urandom);
        end
      end
      bus.start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_layer(1'b0, 0);
    end
  endtask

  task automatic test_back_to_back();
    fill(16'h0200, 16'hFF00);
    run_layer(1'b0, 0);
    fill(16'h0100, 16'h0080);
    run_layer(1'b0, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    fill('0, '0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_sched.md
# fc_sched

Time-multiplexed sequencer for the fully-connected layer. It shares a bank of `LANES` multiply-accumulate lanes across all `NUM_OUT` output neurons, in `ceil(NUM_OUT/LANES)` passes. In each pass it generates addresses into the input-vector buffer and the weight memory, accumulates the products, then drains the requantised results one per cycle to the result buffer. It sits between the convolution/pooling output buffer and the classifier output, and replaces the fully-parallel FC array when area is constrained.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of the signed fixed-point activation, weight and result words.
- `NUM_IN`, 100: input-vector length.
- `NUM_OUT`, 10: number of output neurons.
- `LANES`, 5: number of parallel MAC lanes. `PASSES` = ceil(`NUM_OUT`/`LANES`).
- `FRAC_BITS`, 8: number of fractional bits in activations, weights and results.
- `ACC_WIDTH`, 40: width of the signed accumulator in each lane.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  starts one full layer evaluation; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last result has been written.
- `in_addr`  out  clog2(NUM_IN)  read address into the input buffer.
- `in_data`  in  DATA_WIDTH  input-buffer read data; valid 1 cycle after `in_addr`.
- `w_addr`  out  clog2(PASSES*NUM_IN)  read address into the weight memory.
- `w_data`  in  LANES*DATA_WIDTH  weight-memory read data; valid 1 cycle after `w_addr`. Slice l holds the weight for neuron pass*LANES+l.
- `res_we`  out  1  result write strobe.
- `res_addr`  out  clog2(NUM_OUT)  result index.
- `res_data`  out  DATA_WIDTH  requantised result.

## Operation
- FSM states: IDLE, FETCH, TAIL, WRITE, DONE.
- IDLE:
  - On `start`=1: go to FETCH, set pass=0 and idx=0, clear all accumulators.
- FETCH:
  - Drive `in_addr`=idx and `w_addr`=pass*NUM_IN+idx.
  - idx increments every cycle.
  - After idx=NUM_IN-1, go to TAIL.
- Accumulation:
  - A 1-cycle delayed valid flag marks the data returned for each issued address.
  - When the flag is set, each lane does acc[l] += sext(in_data × w_data[l]).
  - The product is the full 2*DATA_WIDTH signed result, sign-extended to ACC_WIDTH.
- TAIL: accumulates the final product, then goes to WRITE with lane=0.
- WRITE:
  - Each cycle: `res_we`=1, `res_addr`=pass*LANES+lane, `res_data`=requant(acc[lane]).
  - The pass writes only valid lanes: min(LANES, NUM_OUT−pass*LANES) cycles. Lanes beyond NUM_OUT are never written.
  - After the last valid lane: if pass<PASSES-1, increment pass, set idx=0, clear the accumulators and go to FETCH. Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- requant(a):
  - Arithmetic shift right by FRAC_BITS (truncation toward −∞).
  - Then saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- `start` is ignored while `busy`=1. It is not queued.
- Reset (`rst`=0), at any time including mid-pass:
  - Next state is IDLE; pass, idx and lane are 0; accumulators are 0.
  - `busy`, `done` and `res_we` are 0; `in_addr`, `w_addr`, `res_addr` and `res_data` are 0.
  - No partial results are written after reset.

## Timing
- Let S be the cycle in which `start` is sampled in IDLE.
- First pass:
  - FETCH occupies S+1 … S+NUM_IN.
  - TAIL is at S+NUM_IN+1.
  - WRITE starts at S+NUM_IN+2.
- Each pass costs NUM_IN+1+(lanes written) cycles.
- `done` is high in cycle S + PASSES*(NUM_IN+1) + NUM_OUT + 1. With the default parameters this is S+213.
- `busy` rises in S+1 and falls in the cycle after `done`.
- A new `start` can be accepted in the first IDLE cycle after `done`.
- `res_we` is never asserted outside WRITE. Results are written in increasing `res_addr` order, 0 … NUM_OUT−1, exactly once each.

## Configuration
- `FC_SCHED_RELU_EN`:
  - Defined: after saturation, any negative `res_data` is written as 0 (ReLU is fused into writeback).
  - Undefined: the signed saturated value is written unchanged.
  - Timing is identical in both cases.

## Test plan
All scenarios use NUM_IN=4, NUM_OUT=3, LANES=2, FRAC_BITS=8, DATA_WIDTH=16.
- Basic:
  - Stimulus: all inputs 0x0100 (1.0), all weights 0x0080 (0.5), `start` at S.
  - Response: writes (0,0x0200), (1,0x0200) in S+6, S+7 and (2,0x0200) in S+13; `done` in S+14.
- Saturation:
  - Stimulus: inputs 0x7FFF, weights 0x7FFF.
  - Response: all results 0x7FFF. With inputs 0x8000 and weights 0x7FFF, results are 0x8000 without `FC_SCHED_RELU_EN` and 0x0000 with it.
- Address sequence:
  - Response: `w_addr` runs 0,1,2,3 in pass 0 and 4,5,6,7 in pass 1; `in_addr` runs 0..3 in both passes.
  - Lane 1 of pass 1 (neuron 3) is never written.
- Start while busy:
  - Stimulus: pulse `start` at S+3 and S+10.
  - Response: same write sequence and `done` at S+14; no second run.
- Reset mid-operation:
  - Stimulus: `rst`=0 at S+6.
  - Response: from S+7, `busy`=0, `res_we`=0 and all outputs are 0. A fresh `start` then produces the basic-test results.
